// File: rtl/af_sweep_ctrl.sv
// Contrast-autofocus sweep sequencer: coarse sweep, fine sweep around the best coarse
// point, then park the voice-coil motor at the global sharpness peak.
module af_sweep_ctrl #(
    parameter int unsigned W_SHARP       = 24,
    parameter int unsigned COARSE_INC    = 10,
    parameter logic [10:0] COARSE_LAST   = 11'h3F0,
    parameter int unsigned FINE_HALF     = 5,
    parameter int unsigned FINE_INC      = 1,
    parameter int unsigned STEP_MAX      = 1023,
    parameter int unsigned SETTLE_FRAMES = 2,
    parameter int unsigned ACK_TMO       = 65535
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               ABORT,
    input  logic               FRAME_END,
    input  logic               SHARP_VLD,
    input  logic [W_SHARP-1:0] SHARP_VAL,
    output logic [10:0]        STEP,
    output logic               STEP_WR,
    input  logic               STEP_ACK,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR,
    output logic [10:0]        PEAK_STEP,
    output logic [W_SHARP-1:0] PEAK_VAL
);

    localparam int unsigned TMR_W = $clog2(ACK_TMO + 1);

    localparam logic [11:0]      C_INC   = 12'(COARSE_INC);
    localparam logic [11:0]      C_LAST  = {1'b0, COARSE_LAST};
    localparam logic [11:0]      F_HALF  = 12'(FINE_HALF);
    localparam logic [11:0]      F_INC   = 12'(FINE_INC);
    localparam logic [11:0]      S_MAX   = 12'(STEP_MAX);
    localparam logic [3:0]       SET_END = 4'(SETTLE_FRAMES - 1);
    localparam logic [TMR_W-1:0] TMO     = TMR_W'(ACK_TMO);

    typedef enum logic [3:0] {
        S_IDLE, S_MOVE, S_WAIT_ACK, S_SETTLE, S_MEAS,
        S_NEXT, S_PARK, S_PARK_ACK, S_DONE, S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [11:0]        cur_q, cur_d;
    logic [11:0]        hi_q, hi_d;
    logic               fine_q, fine_d;
    logic [W_SHARP-1:0] best_val_q, best_val_d;
    logic [10:0]        best_step_q, best_step_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [3:0]         settle_q, settle_d;
    logic [10:0]        step_q, step_d;
    logic               step_wr_q, step_wr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [10:0]        peak_step_q, peak_step_d;
    logic [W_SHARP-1:0] peak_val_q, peak_val_d;

    logic [11:0] best_ext;
    logic [11:0] nxt_coarse;
    logic [11:0] nxt_fine;
    logic [11:0] fine_lo;
    logic [11:0] fine_hi;

    // Sweep arithmetic in 12 bits so nothing wraps; window edges clamp to 0 and STEP_MAX.
    always_comb begin
        best_ext   = {1'b0, best_step_q};
        nxt_coarse = cur_q + C_INC;
        nxt_fine   = cur_q + F_INC;
        if (best_ext >= F_HALF) begin
            fine_lo = best_ext - F_HALF;
        end else begin
            fine_lo = 12'd0;
        end
        if ((best_ext + F_HALF) > S_MAX) begin
            fine_hi = S_MAX;
        end else begin
            fine_hi = best_ext + F_HALF;
        end
    end

    // Next-state and datapath: ABORT overrides everything, ACK beats a coincident timeout.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        hi_d        = hi_q;
        fine_d      = fine_q;
        best_val_d  = best_val_q;
        best_step_d = best_step_q;
        timer_d     = timer_q;
        settle_d    = settle_q;
        step_d      = step_q;
        step_wr_d   = 1'b0;
        done_d      = done_q;
        err_d       = err_q;
        peak_step_d = peak_step_q;
        peak_val_d  = peak_val_q;

        if (ABORT) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (START) begin
                        cur_d       = 12'd0;
                        fine_d      = 1'b0;
                        best_val_d  = '0;
                        best_step_d = 11'd0;
                        done_d      = 1'b0;
                        err_d       = 1'b0;
                        state_d     = S_MOVE;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_MOVE: begin
                    step_d    = cur_q[10:0];
                    step_wr_d = 1'b1;
                    timer_d   = '0;
                    state_d   = S_WAIT_ACK;
                end
                S_WAIT_ACK, S_PARK_ACK: begin
                    if (STEP_ACK) begin
                        if (state_q == S_PARK_ACK) begin
                            done_d      = 1'b1;
                            peak_step_d = best_step_q;
                            peak_val_d  = best_val_q;
                            state_d     = S_DONE;
                        end else begin
                            settle_d = 4'd0;
                            state_d  = S_SETTLE;
                        end
                    end else if (timer_q == TMO) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_SETTLE: begin
                    // SHARP_VLD here belongs to a frame exposed while the lens was moving.
                    if (FRAME_END) begin
                        if (settle_q == SET_END) begin
                            state_d = S_MEAS;
                        end else begin
                            settle_d = settle_q + 4'd1;
                        end
                    end else begin
                        settle_d = settle_q;
                    end
                end
                S_MEAS: begin
                    if (SHARP_VLD) begin
                        if (SHARP_VAL > best_val_q) begin
                            best_val_d  = SHARP_VAL;
                            best_step_d = cur_q[10:0];
                        end else begin
                            best_val_d = best_val_q;
                        end
                        state_d = S_NEXT;
                    end else begin
                        state_d = S_MEAS;
                    end
                end
                S_NEXT: begin
                    if (!fine_q) begin
                        if ((cur_q > C_LAST) || (nxt_coarse > S_MAX)) begin
                            fine_d = 1'b1;
                            cur_d  = fine_lo;
                            hi_d   = fine_hi;
                        end else begin
                            cur_d = nxt_coarse;
                        end
                        state_d = S_MOVE;
                    end else if (cur_q >= hi_q) begin
                        state_d = S_PARK;
                    end else begin
                        if (nxt_fine > hi_q) begin
                            cur_d = hi_q;
                        end else begin
                            cur_d = nxt_fine;
                        end
                        state_d = S_MOVE;
                    end
                end
                S_PARK: begin
                    step_d    = best_step_q;
                    step_wr_d = 1'b1;
                    timer_d   = '0;
                    state_d   = S_PARK_ACK;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cur_q       <= 12'd0;
            hi_q        <= 12'd0;
            fine_q      <= 1'b0;
            best_val_q  <= '0;
            best_step_q <= 11'd0;
            timer_q     <= '0;
            settle_q    <= 4'd0;
            step_q      <= 11'd0;
            step_wr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            peak_step_q <= 11'd0;
            peak_val_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            hi_q        <= hi_d;
            fine_q      <= fine_d;
            best_val_q  <= best_val_d;
            best_step_q <= best_step_d;
            timer_q     <= timer_d;
            settle_q    <= settle_d;
            step_q      <= step_d;
            step_wr_q   <= step_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            peak_step_q <= peak_step_d;
            peak_val_q  <= peak_val_d;
        end
    end

    assign STEP      = step_q;
    assign STEP_WR   = step_wr_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign PEAK_STEP = peak_step_q;
    assign PEAK_VAL  = peak_val_q;

endmodule

// File: tb/tb_af_sweep_ctrl.sv
// Scoreboard bench for af_sweep_ctrl: expected STEP writes are queued per run and
// compared as the DUT issues them; a lens model returns sharpness for the current STEP.
module tb_af_sweep_ctrl;

    localparam int W   = 24;
    localparam int TMO = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          START;
    logic          ABORT;
    logic          FRAME_END;
    logic          SHARP_VLD;
    logic [W-1:0]  SHARP_VAL;
    logic [10:0]   STEP;
    logic          STEP_WR;
    logic          STEP_ACK;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic [10:0]   PEAK_STEP;
    logic [W-1:0]  PEAK_VAL;

    int checks = 0;
    int errors = 0;
    int metric_mode = 0;
    int ack_limit = 1000000;
    int acks_given = 0;
    int wr_cnt = 0;
    logic [10:0] exp_q[$];

    af_sweep_ctrl #(.ACK_TMO(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
        .FRAME_END(FRAME_END), .SHARP_VLD(SHARP_VLD), .SHARP_VAL(SHARP_VAL),
        .STEP(STEP), .STEP_WR(STEP_WR), .STEP_ACK(STEP_ACK), .BUSY(BUSY),
        .DONE(DONE), .ERR(ERR), .PEAK_STEP(PEAK_STEP), .PEAK_VAL(PEAK_VAL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] metric(input logic [10:0] s);
        int d;
        int pk;
        pk = (metric_mode == 0) ? 503 : 2;
        d  = (int'(s) > pk) ? int'(s) - pk : pk - int'(s);
        if (metric_mode == 2) begin
            return 24'd100;
        end
        return 24'(100000 - d * 50);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Lens / sensor / I2C environment: frames every 8 cycles, ACK 3 cycles after a write,
    // and a bogus max-value SHARP_VLD in the cycle after every ACK (DUT is settling then).
    initial begin
        int fcnt;
        int ack_dly;
        logic glitch_due;
        fcnt = 0; ack_dly = 0; glitch_due = 1'b0;
        FRAME_END = 1'b0; SHARP_VLD = 1'b0; SHARP_VAL = '0; STEP_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            fcnt = (fcnt == 7) ? 0 : fcnt + 1;
            FRAME_END = (fcnt == 0);
            SHARP_VLD = (fcnt == 1);
            SHARP_VAL = (fcnt == 1) ? metric(STEP) : '0;
            if (glitch_due) begin
                SHARP_VLD = 1'b1;
                SHARP_VAL = 24'hFFFFFF;
            end
            glitch_due = STEP_ACK;
            STEP_ACK = 1'b0;
            if (ack_dly != 0) begin
                ack_dly--;
                if (ack_dly == 0) STEP_ACK = 1'b1;
            end
            if (STEP_WR === 1'b1 && acks_given < ack_limit) begin
                ack_dly = 3;
                acks_given++;
            end
        end
    end

    // Scoreboard consumer: every STEP_WR must match the next queued STEP.
    initial begin
        logic [10:0] exp_v;
        forever begin
            @(negedge CLK);
            if (STEP_WR === 1'b1) begin
                wr_cnt++;
                check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    check("wr_step", STEP, exp_v);
                end
            end
        end
    end

    task automatic build_expect(output logic [10:0] pk, output logic [W-1:0] pv, output int nwr);
        int cur, best_s, lo, hi;
        logic [W-1:0] best_v, v;
        bit last;
        cur = 0; best_s = 0; best_v = '0; nwr = 0;
        do begin
            exp_q.push_back(11'(cur)); nwr++;
            v = metric(11'(cur));
            if (v > best_v) begin best_v = v; best_s = cur; end
            last = (cur > 1008) || (cur + 10 > 1023);
            if (!last) cur = cur + 10;
        end while (!last);
        lo = (best_s >= 5) ? best_s - 5 : 0;
        hi = (best_s + 5 > 1023) ? 1023 : best_s + 5;
        for (int c = lo; c <= hi; c++) begin
            exp_q.push_back(11'(c)); nwr++;
            v = metric(11'(c));
            if (v > best_v) begin best_v = v; best_s = c; end
        end
        exp_q.push_back(11'(best_s)); nwr++;
        pk = 11'(best_s);
        pv = best_v;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick(1);
        START = 1'b0;
        check("busy_after_start", BUSY, 1);
    endtask

    task automatic wait_wr(input int budget, output bit seen);
        int cyc;
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < budget) begin
            tick(1); cyc++;
            if (STEP_WR === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic run_full(input int mode, output logic [10:0] pk, output logic [W-1:0] pv,
                            output int nwr);
        int cyc;
        metric_mode = mode; acks_given = 0; ack_limit = 1000000;
        exp_q.delete();
        build_expect(pk, pv, nwr);
        wr_cnt = 0;
        pulse_start();
        cyc = 0;
        while (DONE !== 1'b1 && ERR !== 1'b1 && cyc < 10000) begin
            tick(1); cyc++;
        end
        check("done_level", DONE, 1);
        check("err_level", ERR, 0);
        check("busy_done", BUSY, 0);
        check("peak_step", PEAK_STEP, pk);
        check("peak_val", PEAK_VAL, pv);
        check("park_step", STEP, pk);
        check("wr_count", wr_cnt, nwr);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [10:0] pk;
        logic [W-1:0] pv;
        int nwr, n, prev_wr;
        bit seen;

        RESET = 1'b1; START = 1'b0; ABORT = 1'b0;
        tick(2);
        check("rst_step", STEP, 0);
        check("rst_step_wr", STEP_WR, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        check("rst_peak_step", PEAK_STEP, 0);
        check("rst_peak_val", PEAK_VAL, 0);
        RESET = 1'b0;
        tick(2);

        // Peak at 503: 102 coarse + 11 fine + park
        run_full(0, pk, pv, nwr);
        check("peak503_step", PEAK_STEP, 503);
        check("peak503_writes", nwr, 114);
        check("peak503_val", PEAK_VAL, 100000);

        // Peak near zero: fine window clamps at 0
        run_full(1, pk, pv, nwr);
        check("peak2_step", PEAK_STEP, 2);

        // Flat metric: ties keep the lowest step
        run_full(2, pk, pv, nwr);
        check("flat_step", PEAK_STEP, 0);
        check("flat_val", PEAK_VAL, 100);

        // ACK withheld on the third write -> ERR after 17 cycles in WAIT_ACK
        metric_mode = 0; acks_given = 0; ack_limit = 2;
        exp_q.delete();
        exp_q.push_back(11'd0); exp_q.push_back(11'd10); exp_q.push_back(11'd20);
        pulse_start();
        n = 0;
        while (n < 3) begin
            wait_wr(200, seen);
            if (!seen) begin check("tmo_wr_seen", seen, 1); break; end
            n++;
        end
        n = 0;
        while (ERR !== 1'b1 && n < 100) begin tick(1); n++; end
        check("tmo_cycles", n, 17);
        check("tmo_err", ERR, 1);
        check("tmo_busy", BUSY, 0);
        check("tmo_done", DONE, 0);

        // Restart from ERR, then ABORT while settling at coarse step 200
        ack_limit = 1000000;
        exp_q.delete();
        for (int c = 0; c <= 200; c += 10) exp_q.push_back(11'(c));
        pulse_start();
        check("restart_err_clr", ERR, 0);
        wait_wr(50, seen);
        check("restart_first_step", STEP, 0);
        n = 0;
        while (!(STEP_WR === 1'b1 && STEP == 11'd200) && n < 2000) begin tick(1); n++; end
        check("abort_reach_200", STEP, 200);
        n = 0;
        while (STEP_ACK !== 1'b1 && n < 20) begin tick(1); n++; end
        tick(2);
        ABORT = 1'b1;
        tick(1);
        ABORT = 1'b0;
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_err", ERR, 0);
        check("abort_step_hold", STEP, 200);
        check("abort_peak_hold", PEAK_VAL, 100);
        prev_wr = wr_cnt;
        tick(200);
        check("abort_no_wr", wr_cnt, prev_wr);
        check("abort_queue", exp_q.size(), 0);

        // Async reset in the middle of the fine sweep
        metric_mode = 0; acks_given = 0;
        exp_q.delete();
        build_expect(pk, pv, nwr);
        pulse_start();
        n = 0;
        while (n < 105) begin
            wait_wr(200, seen);
            if (!seen) begin check("mid_fine_wr_seen", seen, 1); break; end
            n++;
        end
        tick(2);
        RESET = 1'b1;
        #1;
        check("arst_step", STEP, 0);
        check("arst_busy", BUSY, 0);
        check("arst_done", DONE, 0);
        check("arst_err", ERR, 0);
        check("arst_peak_step", PEAK_STEP, 0);
        check("arst_peak_val", PEAK_VAL, 0);
        exp_q.delete();
        tick(2);
        RESET = 1'b0;
        prev_wr = wr_cnt;
        tick(100);
        check("arst_no_wr", wr_cnt, prev_wr);
        check("arst_idle", BUSY, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
